fir_tap_sequencer: RTL and testbench
====================================

FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 8, meaning the number of filter taps (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning a new sample is present.
REQ-005 SHALL have port in_data, input, 32, the new sample in two's complement.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-007 SHALL have port coef_we, input, 1, the coefficient write strobe.
REQ-008 SHALL have port coef_addr, input, 4, the tap index being written.
REQ-009 SHALL have port coef_data, input, 11, the raw 11-bit coefficient (multiplier y operand).
REQ-010 SHALL have port mult_x, output, 32, the sample operand driven to the combinational multiplier.
REQ-011 SHALL have port mult_y, output, 11, the coefficient operand driven to the multiplier.
REQ-012 SHALL have port mult_p, input, 32, the multiplier product, valid in the same cycle as mult_x and mult_y.
REQ-013 SHALL have port out_valid, output, 1, meaning a filter result is present.
REQ-014 SHALL have port out_data, output, 32, the filter result.
REQ-015 SHALL have port out_ready, input, 1, meaning the consumer takes the result.

Function
REQ-016 SHALL keep a delay line d[0..NTAPS-1] of 32-bit samples, where d[0] is the newest, and a coefficient file c[0..NTAPS-1] of 11-bit values.
REQ-017 SHALL implement the FSM states IDLE, MAC, and OUT.
REQ-018 SHALL assert in_ready only in IDLE.
REQ-019 SHALL, on in_valid&&in_ready: shift the delay line (d[k]<=d[k-1], d[0]<=in_data), clear the accumulator to 0, set the tap index to 0, and enter MAC.
REQ-020 SHALL, in MAC, drive mult_x=d[idx] and mult_y=c[idx] combinationally from the tap index, add the accumulator to mult_p modulo 2^32 (no saturation), and increment idx.
REQ-021 SHALL enter OUT on the cycle after the MAC cycle with idx=NTAPS-1, so the block spends exactly NTAPS cycles in MAC.
REQ-022 SHALL, in OUT, assert out_valid with out_data equal to the accumulator, and hold both stable until out_ready=1.
REQ-023 SHALL, on out_valid&&out_ready, return to IDLE on the next cycle.
REQ-024 SHALL give a latency from the accept edge at cycle T to the first cycle with out_valid=1 of T+NTAPS+1.
REQ-025 SHALL give a maximum throughput of one sample per NTAPS+2 cycles.
REQ-026 SHALL accept no input in OUT even if out_ready=1 (no bypass), and SHALL leave in_data ignored when in_ready=0.
REQ-027 SHALL drive mult_x=0 and mult_y=0 outside MAC.
REQ-028 SHALL write c[coef_addr]<=coef_data on coef_we only in IDLE with coef_addr<NTAPS; other writes SHALL be dropped silently.
REQ-029 SHALL, when coef_we and an input accept occur in the same IDLE cycle, apply both, with the written coefficient used by the MAC that follows.
REQ-030 SHALL drive out_data=0 whenever out_valid=0.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, force the state to IDLE, clear all d[k], c[k], the accumulator, and idx to 0, regardless of the current state.
REQ-032 SHALL, after reset, hold in_ready=1, out_valid=0, out_data=0, mult_x=0, and mult_y=0.
REQ-033 SHALL, when rst occurs mid-MAC or mid-OUT, discard the pending result with no out_valid pulse.

Verification
REQ-034 SHALL pass a reset check: assert rst 2 cycles -> in_ready=1, out_valid=0, out_data=0, mult_x=0, mult_y=0; all taps read back 0 via an all-zero output for input 5.
REQ-035 SHALL pass an impulse test: bench model mult_p = x*sext(y) (low 32 bits), c[k]=k+1, inputs 1,0,0,0,0,0,0,0 -> outputs 1,2,3,4,5,6,7,8, each out_valid exactly 9 cycles after its accept.
REQ-036 SHALL pass a backpressure test: out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0 throughout, in_valid ignored; out_ready=1 -> in_ready=1 the next cycle.
REQ-037 SHALL pass a wrap-around test: mult_p forced to 0x80000000 for 2 taps and 0 for the rest -> out_data=0x00000000.
REQ-038 SHALL pass a dropped-write test: coef_we during MAC, and coef_we with coef_addr=9 in IDLE -> no coefficient changes and the next result is unchanged.
REQ-039 SHALL pass a mid-operation reset test: rst at MAC cycle 3 -> no out_valid; the next sample 2 with c[0]=3 and other taps zeroed yields out_data=6.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// -----------------------------------------------------------------------------
// fir_tap_sequencer
//
// Sequential FIR filter controller. Each accepted sample is shifted into a
// delay line, then the block walks the taps one per cycle, presenting the
// sample/coefficient pair to an external combinational multiplier and summing
// the returned products modulo 2^32. The result is held on the output until
// the consumer takes it.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : new sample present
//   in_data    : 32-bit two's complement sample
//   in_ready   : block accepts a sample this cycle (IDLE only)
//   coef_we    : coefficient write strobe (honoured in IDLE only)
//   coef_addr  : tap index being written (writes at or above NTAPS are dropped)
//   coef_data  : raw 11-bit coefficient
//   mult_x     : sample operand to the multiplier (0 outside MAC)
//   mult_y     : coefficient operand to the multiplier (0 outside MAC)
//   mult_p     : multiplier product, same-cycle as mult_x/mult_y
//   out_valid  : filter result present
//   out_data   : filter result (0 while out_valid is low)
//   out_ready  : consumer takes the result
// -----------------------------------------------------------------------------
module fir_tap_sequencer #(
    parameter int NTAPS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        coef_we,
    input  logic [3:0]  coef_addr,
    input  logic [10:0] coef_data,
    output logic [31:0] mult_x,
    output logic [10:0] mult_y,
    input  logic [31:0] mult_p,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t          state_reg;
    logic [31:0]     acc_reg;
    logic [IW-1:0]   idx_reg;
    logic [31:0]     d_reg [NTAPS];
    logic [10:0]     c_reg [NTAPS];

    logic            accept;
    logic            coef_wr_ok;

    assign accept     = in_valid && (state_reg == IDLE);
    assign coef_wr_ok = coef_we && (state_reg == IDLE);

    // Delay line: d[0] is the newest sample; everything moves one slot on accept.
    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_delay
            always_ff @(posedge clk) begin
                if (rst) begin
                    d_reg[gi] <= '0;
                end else if (accept) begin
                    if (gi == 0) begin
                        d_reg[gi] <= in_data;
                    end else begin
                        d_reg[gi] <= d_reg[(gi > 0) ? gi - 1 : 0];
                    end
                end
            end
        end
    endgenerate

    // Coefficient file. Matching the full 4-bit address against each tap index
    // means out-of-range addresses simply match no register and are dropped.
    // A write in the same IDLE cycle as an accept lands before MAC starts.
    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_coef
            always_ff @(posedge clk) begin
                if (rst) begin
                    c_reg[gi] <= '0;
                end else if (coef_wr_ok && (coef_addr == 4'(gi))) begin
                    c_reg[gi] <= coef_data;
                end
            end
        end
    endgenerate

    // Control FSM: one IDLE cycle to accept, NTAPS MAC cycles, then OUT until
    // the consumer takes the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        acc_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= MAC;
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + mult_p;
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == IW'(NTAPS - 1)) begin
                        state_reg <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Multiplier operands come straight from the tap index so the product is
    // available in the same MAC cycle; they are parked at zero otherwise.
    always_comb begin
        mult_x = '0;
        mult_y = '0;
        if (state_reg == MAC) begin
            mult_x = d_reg[idx_reg];
            mult_y = c_reg[idx_reg];
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == OUT);
    assign out_data  = (state_reg == OUT) ? acc_reg : '0;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_tap_sequencer
//
// Directed bench for fir_tap_sequencer (NTAPS = 8). The multiplier is modelled
// here as x * sign_extend(y), low 32 bits, with an optional override that
// returns 0x80000000 for coefficients 1 and 2 to exercise accumulator wrap.
// -----------------------------------------------------------------------------
module tb_fir_tap_sequencer;

    localparam int NTAPS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [10:0] coef_data = '0;
    logic [31:0] mult_x;
    logic [10:0] mult_y;
    logic [31:0] mult_p;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;

    logic        wrap_mode = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mult_p = wrap_mode
        ? (((mult_y == 11'd1) || (mult_y == 11'd2)) ? 32'h8000_0000 : 32'h0)
        : mult_x * {{21{mult_y[10]}}, mult_y};

    fir_tap_sequencer #(.NTAPS(NTAPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .mult_x    (mult_x),
        .mult_y    (mult_y),
        .mult_p    (mult_p),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic write_coef(input logic [3:0] addr, input logic [10:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Offer one sample, wait (bounded) for the result, check latency and value.
    // mac_we: hold a coefficient write (addr 2) through MAC, which must be dropped.
    // same_we: write c[0]=3 in the accept cycle, which must be applied.
    task automatic run_sample(input string tag, input logic [31:0] data,
                              input logic [31:0] exp, input bit mac_we, input bit same_we);
        int cnt;
        @(negedge clk);
        check_val({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        if (same_we) begin
            coef_we   = 1'b1;
            coef_addr = 4'd0;
            coef_data = 11'd3;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 32'hdead_beef;
        coef_we  = 1'b0;
        if (mac_we) begin
            coef_we   = 1'b1;
            coef_addr = 4'd2;
            coef_data = 11'd100;
        end
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        coef_we = 1'b0;
        check_val({tag, "_latency"}, cnt, 32'd9);
        check_val({tag, "_out_data"}, out_data, exp);
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit saw_valid;

        // Reset state
        do_reset();
        @(posedge clk);
        #1;
        check_val("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst_out_data", out_data, 32'd0);
        check_val("rst_mult_x", mult_x, 32'd0);
        check_val("rst_mult_y", {21'b0, mult_y}, 32'd0);
        run_sample("rst_taps_zero", 32'd5, 32'd0, 1'b0, 1'b0);

        // Impulse response with c[k] = k+1
        do_reset();
        for (int k = 0; k < NTAPS; k++) begin
            write_coef(4'(k), 11'(k + 1));
        end
        for (int k = 0; k < NTAPS; k++) begin
            run_sample($sformatf("impulse%0d", k), (k == 0) ? 32'd1 : 32'd0,
                       32'(k + 1), 1'b0, 1'b0);
        end

        // Backpressure: d = [3,0..0] -> result 3, held while out_ready low
        out_ready = 1'b0;
        run_sample("bp", 32'd3, 32'd3, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'd99;
            @(posedge clk);
            #1;
            check_val($sformatf("bp_hold%0d_valid", k), {31'b0, out_valid}, 32'd1);
            check_val($sformatf("bp_hold%0d_data", k), out_data, 32'd3);
            check_val($sformatf("bp_hold%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
            check_val($sformatf("bp_hold%0d_mult_x", k), mult_x, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        check_val("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("bp_release_out_data", out_data, 32'd0);

        // Wrap-around: two taps return 0x80000000, sum wraps to zero
        @(negedge clk);
        wrap_mode = 1'b1;
        run_sample("wrap", 32'd7, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        wrap_mode = 1'b0;

        // Dropped writes: addr 9 in IDLE and addr 2 during MAC.
        // d = [0,7,3,0..] with c = 1..8 -> 7*2 + 3*3 = 23
        write_coef(4'd9, 11'd100);
        run_sample("dropped_we", 32'd0, 32'd23, 1'b1, 1'b0);

        // Mid-MAC reset: no result may appear afterwards
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            saw_valid |= out_valid;
        end
        check_val("midrst_no_valid", {31'b0, saw_valid}, 32'd0);
        check_val("midrst_in_ready", {31'b0, in_ready}, 32'd1);

        // Coefficient write in the accept cycle: c[0]=3, sample 2 -> 6
        run_sample("same_cycle_we", 32'd2, 32'd6, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
